cpu_datapath: RTL and testbench
===============================

CPU_DATAPATH -- requirements
Module: cpu_datapath

Interface
REQ-001 SHALL have parameter DWIDTH, default 8, data/accumulator/instruction width.
REQ-002 SHALL have parameter AWIDTH, default 5, address and program-counter width; DWIDTH = AWIDTH + 3 always.
REQ-003 SHALL have port clk  input  1  single clock; all state updates on rising edge.
REQ-004 SHALL have port rst_  input  1  reset, asynchronous, active-low.
REQ-005 SHALL have port data_in  input  DWIDTH  memory read data.
REQ-006 SHALL have port ld_ir  input  1  load instruction register from data_in.
REQ-007 SHALL have port ld_ac  input  1  load accumulator from ALU result.
REQ-008 SHALL have port ld_pc  input  1  load PC from IR address field.
REQ-009 SHALL have port inc_pc  input  1  increment PC.
REQ-010 SHALL have port sel  input  1  address select: 1 = PC, 0 = IR address field.
REQ-011 SHALL have port data_e  input  1  drive-enable for accumulator onto memory write bus.
REQ-012 SHALL have port halt  input  1  halt request from sequencer.
REQ-013 SHALL have port opcode  output  3  IR[DWIDTH-1:DWIDTH-3], to sequencer.
REQ-014 SHALL have port zero  output  1  high when accumulator equals 0, to sequencer.
REQ-015 SHALL have port addr  output  AWIDTH  memory address.
REQ-016 SHALL have port data_out  output  DWIDTH  accumulator value for memory write.
REQ-017 SHALL have port data_oe  output  1  write-bus enable.
REQ-018 SHALL have port halted  output  1  sticky halt status.

Function
REQ-019 SHALL hold IR, AC (DWIDTH each), PC (AWIDTH), halted flag as registers.
REQ-020 SHALL capture data_in into IR on a clk edge with ld_ir=1 and halted=0.
REQ-021 SHALL compute ALU result combinationally from current IR opcode, AC, data_in: 0 HLT -> AC; 1 SKZ -> AC; 2 ADD -> (AC + data_in) mod 2^DWIDTH, carry discarded; 3 AND -> AC & data_in; 4 XOR -> AC ^ data_in; 5 LDA -> data_in; 6 STO -> AC; 7 JMP -> AC.
REQ-022 SHALL load ALU result into AC on a clk edge with ld_ac=1 and halted=0.
REQ-023 SHALL, when ld_ir and ld_ac are both 1 in one cycle, compute AC from the pre-edge IR opcode.
REQ-024 SHALL load PC from IR[AWIDTH-1:0] (pre-edge IR) when ld_pc=1 and halted=0.
REQ-025 SHALL increment PC by 1 when inc_pc=1, ld_pc=0, halted=0; PC wraps from 2^AWIDTH-1 to 0.
REQ-026 SHALL give ld_pc priority over inc_pc when both are 1.
REQ-027 SHALL drive addr = PC when sel=1, IR[AWIDTH-1:0] when sel=0, combinationally.
REQ-028 SHALL drive opcode from IR register and zero from AC register (zero-latency from register, one-cycle latency from ld_ac).
REQ-029 SHALL drive data_out = AC continuously and data_oe = data_e combinationally.
REQ-030 SHALL set halted on the clk edge where halt=1; halted remains 1 until reset.
REQ-031 SHALL, while halted=1, ignore ld_ir, ld_ac, ld_pc, inc_pc (all registers hold); addr, opcode, zero, data_out, data_oe remain combinational functions of held state and inputs.
REQ-032 SHALL, on the edge where halt=1 first samples, still perform any ld_ir/ld_ac/ld_pc/inc_pc in that same cycle.

Reset
REQ-033 SHALL, while rst_=0, force IR=0, AC=0, PC=0, halted=0 immediately, independent of clk.
REQ-034 SHALL present after reset: opcode=0, zero=1, addr=0, data_out=0, halted=0, data_oe=data_e.
REQ-035 SHALL, on reset asserted mid-operation, abandon any load in progress; first update occurs on first clk edge after rst_ returns high.

Verification
REQ-036 SHALL pass: reset, data_in=8'hA3, ld_ir=1 one cycle -> opcode=5, sel=0 gives addr=5'h03.
REQ-037 SHALL pass: IR=8'h40 (ADD), AC=8'hF0, data_in=8'h20, ld_ac=1 -> AC=8'h10, zero=0; then IR=8'h80 (XOR), data_in=8'h10, ld_ac=1 -> AC=0, zero=1 next cycle.
REQ-038 SHALL pass: PC=5'h1F, inc_pc=1, sel=1 -> addr=5'h00; IR=8'hEC, ld_pc=1 and inc_pc=1 together -> PC=5'h0C.
REQ-039 SHALL pass: IR=8'hA7 (LDA), ld_ir=1 with data_in=8'h55 and ld_ac=1 same cycle -> IR=8'h55, AC=8'h55 (LDA from old IR).
REQ-040 SHALL pass: halt=1 one cycle then ld_ir/ld_ac/inc_pc pulsed -> halted=1, IR/AC/PC unchanged; rst_=0 mid-clock -> all cleared without a clk edge.

Source files
------------

// File: rtl/cpu_datapath.sv
// Accumulator CPU datapath: IR, AC and PC registers, combinational ALU and
// address mux, with a sticky halt that freezes all architectural state.
module cpu_datapath #(
  parameter int unsigned DWIDTH = 8,
  parameter int unsigned AWIDTH = 5
) (
  input  logic              clk,
  input  logic              rst_,
  input  logic [DWIDTH-1:0] data_in,
  input  logic              ld_ir,
  input  logic              ld_ac,
  input  logic              ld_pc,
  input  logic              inc_pc,
  input  logic              sel,
  input  logic              data_e,
  input  logic              halt,
  output logic [2:0]        opcode,
  output logic              zero,
  output logic [AWIDTH-1:0] addr,
  output logic [DWIDTH-1:0] data_out,
  output logic              data_oe,
  output logic              halted
);

  localparam int unsigned OPW = 3;

  typedef enum logic [OPW-1:0] {
    OP_HLT = 3'd0,
    OP_SKZ = 3'd1,
    OP_ADD = 3'd2,
    OP_AND = 3'd3,
    OP_XOR = 3'd4,
    OP_LDA = 3'd5,
    OP_STO = 3'd6,
    OP_JMP = 3'd7
  } op_e;

  logic [DWIDTH-1:0] ir_q, ir_d;
  logic [DWIDTH-1:0] ac_q, ac_d;
  logic [AWIDTH-1:0] pc_q, pc_d;
  logic              halted_q, halted_d;
  logic [DWIDTH-1:0] alu_c;
  op_e               op_c;

  assign op_c = op_e'(ir_q[DWIDTH-1 -: OPW]);

  // ALU; opcodes that do not modify the accumulator pass it through
  always_comb begin
    alu_c = ac_q;
    case (op_c)
      OP_ADD:  alu_c = DWIDTH'(ac_q + data_in);
      OP_AND:  alu_c = ac_q & data_in;
      OP_XOR:  alu_c = ac_q ^ data_in;
      OP_LDA:  alu_c = data_in;
      default: alu_c = ac_q;
    endcase
  end

  // Loads use pre-edge state; halted_q (not halt) gates them so the halting
  // cycle itself still completes its loads
  always_comb begin
    ir_d     = ir_q;
    ac_d     = ac_q;
    pc_d     = pc_q;
    halted_d = halted_q;
    if (!halted_q) begin
      if (ld_ir) ir_d = data_in;
      if (ld_ac) ac_d = alu_c;
      if (ld_pc) begin
        pc_d = ir_q[AWIDTH-1:0];
      end else if (inc_pc) begin
        pc_d = AWIDTH'(pc_q + AWIDTH'(1));
      end
    end
    if (halt) halted_d = 1'b1;
  end

  always_ff @(posedge clk or negedge rst_) begin
    if (!rst_) begin
      ir_q     <= '0;
      ac_q     <= '0;
      pc_q     <= '0;
      halted_q <= 1'b0;
    end else begin
      ir_q     <= ir_d;
      ac_q     <= ac_d;
      pc_q     <= pc_d;
      halted_q <= halted_d;
    end
  end

  assign opcode   = ir_q[DWIDTH-1 -: OPW];
  assign zero     = (ac_q == '0);
  assign addr     = sel ? pc_q : ir_q[AWIDTH-1:0];
  assign data_out = ac_q;
  assign data_oe  = data_e;
  assign halted   = halted_q;

endmodule

// File: tb/tb_cpu_datapath.sv
// Self-checking bench for cpu_datapath: vector table through a scoreboard
// queue, plus hand-written reset/latency sequences.
module tb_cpu_datapath;

  logic       clk;
  logic       rst_;
  logic [7:0] data_in;
  logic       ld_ir, ld_ac, ld_pc, inc_pc, sel, data_e, halt;
  logic [2:0] opcode;
  logic       zero;
  logic [4:0] addr;
  logic [7:0] data_out;
  logic       data_oe;
  logic       halted;

  cpu_datapath #(.DWIDTH(8), .AWIDTH(5)) dut (
    .clk      (clk),
    .rst_     (rst_),
    .data_in  (data_in),
    .ld_ir    (ld_ir),
    .ld_ac    (ld_ac),
    .ld_pc    (ld_pc),
    .inc_pc   (inc_pc),
    .sel      (sel),
    .data_e   (data_e),
    .halt     (halt),
    .opcode   (opcode),
    .zero     (zero),
    .addr     (addr),
    .data_out (data_out),
    .data_oe  (data_oe),
    .halted   (halted)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // ctl = {ld_ir, ld_ac, ld_pc, inc_pc, sel, data_e, halt}
  // obs = {opcode, zero, addr, data_out, data_oe, halted}
  typedef struct packed {
    logic [7:0]  din;
    logic [6:0]  ctl;
    logic [18:0] exp;
  } vec_t;

  localparam int NVEC = 25;
  vec_t        vecs [NVEC];
  logic [18:0] exp_q [$];
  int          n_checks = 0;
  int          n_errs   = 0;

  function automatic vec_t mk(input logic [7:0] din, input logic [6:0] ctl,
                              input logic [2:0] op, input logic z, input logic [4:0] a,
                              input logic [7:0] d, input logic oe, input logic h);
    vec_t v;
    v.din = din;
    v.ctl = ctl;
    v.exp = {op, z, a, d, oe, h};
    return v;
  endfunction

  function automatic logic [18:0] obs();
    return {opcode, zero, addr, data_out, data_oe, halted};
  endfunction

  task automatic check(input string name, input logic [18:0] got, input logic [18:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errs++;
      $display("FAIL %s: got op=%0d z=%b addr=%h dout=%h oe=%b halted=%b, expected op=%0d z=%b addr=%h dout=%h oe=%b halted=%b",
               name, got[18:16], got[15], got[14:10], got[9:2], got[1], got[0],
               exp[18:16], exp[15], exp[14:10], exp[9:2], exp[1], exp[0]);
    end
  endtask

  task automatic drive(input logic [7:0] din, input logic [6:0] ctl);
    data_in = din;
    {ld_ir, ld_ac, ld_pc, inc_pc, sel, data_e, halt} = ctl;
  endtask

  initial begin
    #20000;
    $display("FAIL watchdog: got timeout, expected completion");
    $fatal(1, "watchdog expired");
  end

  initial begin
    logic [18:0] e;
    string nm;

    vecs[0]  = mk(8'hA3, 7'b1000000, 3'd5, 1'b1, 5'h03, 8'h00, 1'b0, 1'b0);
    vecs[1]  = mk(8'h40, 7'b1000000, 3'd2, 1'b1, 5'h00, 8'h00, 1'b0, 1'b0);
    vecs[2]  = mk(8'hF0, 7'b0100000, 3'd2, 1'b0, 5'h00, 8'hF0, 1'b0, 1'b0);
    vecs[3]  = mk(8'h20, 7'b0100000, 3'd2, 1'b0, 5'h00, 8'h10, 1'b0, 1'b0);
    vecs[4]  = mk(8'h80, 7'b1000000, 3'd4, 1'b0, 5'h00, 8'h10, 1'b0, 1'b0);
    vecs[5]  = mk(8'h10, 7'b0100000, 3'd4, 1'b1, 5'h00, 8'h00, 1'b0, 1'b0);
    vecs[6]  = mk(8'hA0, 7'b1000000, 3'd5, 1'b1, 5'h00, 8'h00, 1'b0, 1'b0);
    vecs[7]  = mk(8'h3C, 7'b0100000, 3'd5, 1'b0, 5'h00, 8'h3C, 1'b0, 1'b0);
    vecs[8]  = mk(8'h6F, 7'b1000000, 3'd3, 1'b0, 5'h0F, 8'h3C, 1'b0, 1'b0);
    vecs[9]  = mk(8'hF5, 7'b0100000, 3'd3, 1'b0, 5'h0F, 8'h34, 1'b0, 1'b0);
    vecs[10] = mk(8'h2A, 7'b1000000, 3'd1, 1'b0, 5'h0A, 8'h34, 1'b0, 1'b0);
    vecs[11] = mk(8'hFF, 7'b0100010, 3'd1, 1'b0, 5'h0A, 8'h34, 1'b1, 1'b0);
    vecs[12] = mk(8'hA7, 7'b1000000, 3'd5, 1'b0, 5'h07, 8'h34, 1'b0, 1'b0);
    vecs[13] = mk(8'h55, 7'b1100000, 3'd2, 1'b0, 5'h15, 8'h55, 1'b0, 1'b0);
    vecs[14] = mk(8'hEC, 7'b1000100, 3'd7, 1'b0, 5'h00, 8'h55, 1'b0, 1'b0);
    vecs[15] = mk(8'h00, 7'b0011100, 3'd7, 1'b0, 5'h0C, 8'h55, 1'b0, 1'b0);
    vecs[16] = mk(8'h00, 7'b0001100, 3'd7, 1'b0, 5'h0D, 8'h55, 1'b0, 1'b0);
    vecs[17] = mk(8'hFF, 7'b1000100, 3'd7, 1'b0, 5'h0D, 8'h55, 1'b0, 1'b0);
    vecs[18] = mk(8'h00, 7'b0010100, 3'd7, 1'b0, 5'h1F, 8'h55, 1'b0, 1'b0);
    vecs[19] = mk(8'h00, 7'b0001100, 3'd7, 1'b0, 5'h00, 8'h55, 1'b0, 1'b0);
    vecs[20] = mk(8'h00, 7'b0000000, 3'd7, 1'b0, 5'h1F, 8'h55, 1'b0, 1'b0);
    vecs[21] = mk(8'h00, 7'b0100000, 3'd7, 1'b0, 5'h1F, 8'h55, 1'b0, 1'b0);
    vecs[22] = mk(8'h3E, 7'b1001101, 3'd1, 1'b0, 5'h01, 8'h55, 1'b0, 1'b1);
    vecs[23] = mk(8'h00, 7'b1101100, 3'd1, 1'b0, 5'h01, 8'h55, 1'b0, 1'b1);
    vecs[24] = mk(8'h00, 7'b0010010, 3'd1, 1'b0, 5'h1E, 8'h55, 1'b1, 1'b1);

    // Reset state, observed with no clock edge yet
    rst_ = 1'b0;
    drive(8'h00, 7'b0000010);
    #3;
    check("reset_state", obs(), {3'd0, 1'b1, 5'h00, 8'h00, 1'b1, 1'b0});
    data_e = 1'b0;
    #1;
    check("reset_oe_follows", obs(), {3'd0, 1'b1, 5'h00, 8'h00, 1'b0, 1'b0});
    @(negedge clk);
    @(negedge clk);
    rst_ = 1'b1;

    // Table through the scoreboard
    for (int i = 0; i < NVEC; i++) begin
      @(negedge clk);
      drive(vecs[i].din, vecs[i].ctl);
      exp_q.push_back(vecs[i].exp);
      @(posedge clk);
      #1;
      e = exp_q.pop_front();
      nm = $sformatf("vec%0d", i);
      check(nm, obs(), e);
    end

    // Asynchronous reset between edges, while halted and with loads requested
    @(negedge clk);
    drive(8'hFF, 7'b1100000);
    #2;
    rst_ = 1'b0;
    #1;
    check("async_reset", obs(), {3'd0, 1'b1, 5'h00, 8'h00, 1'b0, 1'b0});
    @(posedge clk);
    #1;
    check("reset_blocks_load", obs(), {3'd0, 1'b1, 5'h00, 8'h00, 1'b0, 1'b0});
    @(negedge clk);
    rst_ = 1'b1;
    @(posedge clk);
    #1;
    // IR was HLT, so ld_ac keeps AC at 0 while IR takes FF
    check("first_edge_after_reset", obs(), {3'd7, 1'b1, 5'h1F, 8'h00, 1'b0, 1'b0});

    // zero lags ld_ac by one edge
    @(negedge clk);
    drive(8'hA0, 7'b1000000);
    @(negedge clk);
    drive(8'h07, 7'b0100000);
    #3;
    check("zero_before_edge", obs(), {3'd5, 1'b1, 5'h00, 8'h00, 1'b0, 1'b0});
    @(posedge clk);
    #1;
    check("zero_after_edge", obs(), {3'd5, 1'b0, 5'h00, 8'h07, 1'b0, 1'b0});

    // ADD carry is discarded: 07 + FF = 06
    @(negedge clk);
    drive(8'h40, 7'b1000000);
    @(negedge clk);
    drive(8'hFF, 7'b0100000);
    @(posedge clk);
    #1;
    check("add_wrap", obs(), {3'd2, 1'b0, 5'h00, 8'h06, 1'b0, 1'b0});

    @(negedge clk);
    drive(8'h00, 7'b0000000);
    $display("Result: errors=%0d of %0d checks", n_errs, n_checks);
    $finish;
  end

endmodule
